exp_iter_ctrl: RTL and testbench

//  Sequencer for the iterative e^x datapath. Accepts x (Q4.11, 15 b) on a valid/ready port.

---
 rtl/exp_pkg.sv | 45 ++++
 rtl/exp_iter_ctrl_if.sv | 29 ++
 rtl/exp_y_update.sv | 31 +++
 rtl/exp_iter_ctrl.sv | 152 +++++++++++++++
 tb/tb_exp_iter_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/exp_pkg.sv
// Shared constants for the iterative e^x sequencer: operand format, log tables, state encoding.
package exp_pkg;

  localparam int X_W    = 15;
  localparam int X_FRAC = 11;
  localparam int I_W    = 5;

  localparam logic [X_W-1:0] LN2_Q11 = 15'h058B;

  // ln(1+2^-i) in Q4.11, rounded to nearest; entries from 12 up round to zero
  localparam logic [X_W-1:0] LNF_Q11 [16] = '{
    15'h0000, 15'h033E, 15'h01C9, 15'h00F1,
    15'h007C, 15'h003F, 15'h0020, 15'h0010,
    15'h0008, 15'h0004, 15'h0002, 15'h0001,
    15'h0000, 15'h0000, 15'h0000, 15'h0000
  };

  localparam logic [2:0] ST_IDLE_ENC = 3'd0;
  localparam logic [2:0] ST_CAPT_ENC = 3'd1;
  localparam logic [2:0] ST_SEL_ENC  = 3'd2;
  localparam logic [2:0] ST_UPD_ENC  = 3'd3;
  localparam logic [2:0] ST_DONE_ENC = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_CAPT = ST_CAPT_ENC,
    ST_SEL  = ST_SEL_ENC,
    ST_UPD  = ST_UPD_ENC,
    ST_DONE = ST_DONE_ENC
  } state_t;

  function automatic logic [X_W-1:0] lnf_term(input logic [I_W-1:0] i);
    logic [X_W-1:0] t;
    t = (i[4] == 1'b1) ? '0 : LNF_Q11[i[3:0]];
    return t;
  endfunction

  // k*ln2; selection never picks k large enough to exceed the 15-bit residual
  function automatic logic [X_W-1:0] k_ln2(input logic [I_W-1:0] k);
    logic [X_W+I_W-1:0] p;
    p = {{X_W{1'b0}}, k} * {{I_W{1'b0}}, LN2_Q11};
    return p[X_W-1:0];
  endfunction

endpackage

// File: rtl/exp_iter_ctrl_if.sv
// Operand, result and selection-stage signals of the e^x sequencer.
interface exp_iter_ctrl_if
  import exp_pkg::*;
#(
  parameter int OUT_W = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [X_W-1:0]   x_in;
  logic [X_W-1:0]   sel_data;
  logic [I_W-1:0]   sel_i;
  logic             sel_int;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] y_out;
  logic             ovf;

  modport master (
    output in_valid, x_in, out_ready, sel_i, sel_int,
    input  in_ready, sel_data, out_valid, y_out, ovf
  );

  modport slave (
    input  in_valid, x_in, out_ready, sel_i, sel_int,
    output in_ready, sel_data, out_valid, y_out, ovf
  );

endinterface

// File: rtl/exp_y_update.sv
// Combinational y step: y<<k for integer terms, y+(y>>i) for fractional terms, with overflow flag.
module exp_y_update
  import exp_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic [OUT_W-1:0] y,
  input  logic [I_W-1:0]   sh,
  input  logic             is_int,
  output logic [OUT_W-1:0] y_next,
  output logic             ovf_next
);

  logic [2*OUT_W-1:0] shl;
  logic [OUT_W:0]     sum;

  always_comb begin
    shl      = {{OUT_W{1'b0}}, y} << sh;
    sum      = {1'b0, y} + {1'b0, (y >> sh)};
    y_next   = '0;
    ovf_next = 1'b0;
    if (is_int) begin
      y_next   = shl[OUT_W-1:0];
      ovf_next = |shl[2*OUT_W-1:OUT_W];
    end else begin
      y_next   = sum[OUT_W-1:0];
      ovf_next = sum[OUT_W];
    end
  end

endmodule

// File: rtl/exp_iter_ctrl.sv
// Iterative e^x sequencer: residual/iteration bookkeeping around an external selection stage.
// Build option EXP_SAT_EN: saturate y to all-ones and flag ovf on overflow; otherwise y wraps.
//
//  state | meaning
//  IDLE  | in_ready high, waiting for an operand
//  CAPT  | operand latched; r==0 finishes, else residual goes to selection
//  SEL   | selection stage registers its answer for sel_data
//  UPD   | subtract chosen log term from r, scale y
//  DONE  | result held on y_out/ovf until out_ready
module exp_iter_ctrl
  import exp_pkg::*;
#(
  parameter int OUT_W    = 32,
  parameter int FRAC_W   = 16,
  parameter int MAX_ITER = 24
) (
  input logic             clk,
  input logic             rst_n,
  exp_iter_ctrl_if.slave  bus
);

  localparam int ITER_W = $clog2(MAX_ITER + 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MAX_ITER - 1);
  localparam logic [OUT_W-1:0]  Y_ONE     = OUT_W'(1) << FRAC_W;

  state_t            state;
  logic [X_W-1:0]    r;
  logic [OUT_W-1:0]  y;
  logic              sat;
  logic [ITER_W-1:0] iter;

  logic              in_ready_q;
  logic              out_valid_q;
  logic [OUT_W-1:0]  y_out_q;
  logic              ovf_q;
  logic [X_W-1:0]    sel_data_q;

  logic [X_W-1:0]    r_sub;
  logic [X_W-1:0]    r_next;
  logic              no_term;
  logic [OUT_W-1:0]  y_upd;
  logic              ovf_upd;
  logic [OUT_W-1:0]  y_step;
  logic              sat_step;

  exp_y_update #(.OUT_W(OUT_W)) u_y_update (
    .y        (y),
    .sh       (bus.sel_i),
    .is_int   (bus.sel_int),
    .y_next   (y_upd),
    .ovf_next (ovf_upd)
  );

  always_comb begin
    r_sub   = bus.sel_int ? k_ln2(bus.sel_i) : lnf_term(bus.sel_i);
    r_next  = r - r_sub;
    no_term = !bus.sel_int && (bus.sel_i == '0);
  end

`ifdef EXP_SAT_EN
  // once saturated, y stays all-ones for the rest of the operand
  assign y_step   = (sat || ovf_upd) ? '1 : y_upd;
  assign sat_step = sat || ovf_upd;
`else
  logic unused_ovf;
  assign y_step     = y_upd;
  assign sat_step   = 1'b0;
  assign unused_ovf = ovf_upd;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      r           <= '0;
      y           <= '0;
      sat         <= 1'b0;
      iter        <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      y_out_q     <= '0;
      ovf_q       <= 1'b0;
      sel_data_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            r          <= bus.x_in;
            y          <= Y_ONE;
            iter       <= '0;
            sat        <= 1'b0;
            state      <= ST_CAPT;
          end
        end
        ST_CAPT: begin
          if (r == '0) begin
            out_valid_q <= 1'b1;
            y_out_q     <= y;
            ovf_q       <= sat;
            state       <= ST_DONE;
          end else begin
            sel_data_q <= r;
            state      <= ST_SEL;
          end
        end
        ST_SEL: begin
          state <= ST_UPD;
        end
        ST_UPD: begin
          iter <= iter + 1'b1;
          if (no_term) begin
            out_valid_q <= 1'b1;
            y_out_q     <= y;
            ovf_q       <= sat;
            state       <= ST_DONE;
          end else begin
            r   <= r_next;
            y   <= y_step;
            sat <= sat_step;
            if ((r_next == '0) || (iter == LAST_ITER)) begin
              out_valid_q <= 1'b1;
              y_out_q     <= y_step;
              ovf_q       <= sat_step;
              state       <= ST_DONE;
            end else begin
              sel_data_q <= r_next;
              state      <= ST_SEL;
            end
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.y_out     = y_out_q;
  assign bus.ovf       = ovf_q;
  assign bus.sel_data  = sel_data_q;

endmodule

// File: tb/tb_exp_iter_ctrl.sv
// Directed bench for exp_iter_ctrl with a registered selection-stage model.
module tb_exp_iter_ctrl;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic both_seen;
  logic force_frac;

  exp_iter_ctrl_if #(.OUT_W(32)) bus ();

  exp_iter_ctrl #(.OUT_W(32), .FRAC_W(16), .MAX_ITER(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // selection stage: largest k with k*ln2 <= r, else smallest i with ln(1+2^-i) <= r
  function automatic logic [5:0] sel_fn(input logic [14:0] r);
    logic [14:0] lnf [16];
    logic [5:0]  res;
    lnf = '{15'd0, 15'd830, 15'd457, 15'd241, 15'd124, 15'd63, 15'd32, 15'd16,
            15'd8, 15'd4, 15'd2, 15'd1, 15'd0, 15'd0, 15'd0, 15'd0};
    res = 6'd0;
    if (r >= 15'd1419) begin
      res = {1'b1, 5'(int'(r) / 1419)};
    end else begin
      for (int i = 15; i >= 1; i--) begin
        if (lnf[i] != 0 && lnf[i] <= r) res = {1'b0, 5'(i)};
      end
    end
    return res;
  endfunction

  always @(posedge clk) begin
    if (force_frac) begin
      bus.sel_int <= 1'b0;
      bus.sel_i   <= 5'd15;
    end else begin
      {bus.sel_int, bus.sel_i} <= sel_fn(bus.sel_data);
    end
  end

  always @(negedge clk) begin
    if (bus.in_ready === 1'b1 && bus.out_valid === 1'b1) both_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic start_op(input logic [14:0] x);
    int g;
    g = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x_in     = x;
    while (bus.in_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("accept_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // lat counts rising edges from the accept edge (=1) to the edge raising out_valid
  task automatic wait_done(output int lat);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("done_seen", bus.out_valid, 1);
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("hs_drop_valid", bus.out_valid, 0);
  endtask

  initial begin
    int          lat;
    logic [31:0] y_ref;
    logic        stable;
    logic [31:0] exp_y;
    logic        exp_o;
    logic [14:0] xr;
    real         got, want, rel;

    n_tests       = 0;
    n_fail        = 0;
    both_seen     = 1'b0;
    force_frac    = 1'b0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.out_ready = 1'b0;

    // reset values
    #12;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_y_out", bus.y_out, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_sel_data", bus.sel_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    // 1: x=0, no iterations
    start_op(15'h0000);
    wait_done(lat);
    chk("t1_lat", lat, 2);
    chk("t1_y", bus.y_out, 32'h0001_0000);
    chk("t1_ovf", bus.ovf, 0);
    finish_op();

    // 2: x=ln2, one integer step
    start_op(15'h058B);
    wait_done(lat);
    chk("t2_lat", lat, 4);
    chk("t2_y", bus.y_out, 32'h0002_0000);
    finish_op();

    // 3: x=max, overflows on the first k=23 shift
`ifdef EXP_SAT_EN
    exp_y = 32'hFFFF_FFFF;
    exp_o = 1'b1;
`else
    exp_y = 32'h0000_0000;
    exp_o = 1'b0;
`endif
    start_op(15'h7FFF);
    wait_done(lat);
    chk("t3_y", bus.y_out, exp_y);
    chk("t3_ovf", bus.ovf, exp_o);
    finish_op();

    // 4: back-pressure in DONE, second operand waits for IDLE
    start_op(15'h058B);
    wait_done(lat);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x_in     = 15'h0000;
    y_ref  = bus.y_out;
    stable = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b1 || bus.y_out !== y_ref || bus.ovf !== 1'b0 ||
          bus.in_ready !== 1'b0) stable = 1'b0;
    end
    chk("t4_hold_stable", stable, 1);
    chk("t4_hold_y", y_ref, 32'h0002_0000);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("t4_idle_ready", bus.in_ready, 1);
    chk("t4_idle_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("t4_second_accepted", bus.in_ready, 0);
    wait_done(lat);
    chk("t4_second_lat", lat, 2);
    chk("t4_second_y", bus.y_out, 32'h0001_0000);
    finish_op();

    // 5: async reset during UPD
    start_op(15'h7FFF);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", bus.out_valid, 0);
    chk("t5_rst_y_out", bus.y_out, 0);
    chk("t5_rst_sel_data", bus.sel_data, 0);
    chk("t5_rst_in_ready", bus.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_no_stale_valid", bus.out_valid, 0);
    start_op(15'h058B);
    wait_done(lat);
    chk("t5_lat", lat, 4);
    chk("t5_y", bus.y_out, 32'h0002_0000);
    finish_op();

    // 6: selection stuck on i=15 (zero term): runs to the iteration cap
    force_frac = 1'b1;
    start_op(15'h0001);
    wait_done(lat);
    chk("t6_lat", lat, 50);
    chk("t6_y", bus.y_out, 32'h0001_0030);
    finish_op();
    force_frac = 1'b0;

    // random operands vs real exp; tolerance covers LN2/LNF rounding over several steps
    for (int n = 0; n < 7; n++) begin
      xr = (n == 0) ? 15'h2000 : 15'($urandom_range(0, 32'h2000));
      start_op(xr);
      wait_done(lat);
      got  = real'(bus.y_out) / 65536.0;
      want = $exp(real'(xr) / 2048.0);
      rel  = (got > want) ? (got - want) / want : (want - got) / want;
      chk("rand_rel_err", (rel <= 2.0 ** -8) ? 1 : 0, 1);
      finish_op();
    end

    chk("ready_valid_exclusive", both_seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
